// File: rtl/ai_qcrc_sum_tree.sv
// ai_qcrc_sum_tree
// Pipelined unsigned adder tree that reduces N channel scores to one total
// per beat. It can also accumulate totals over a multi-beat frame, closed by
// in_last, with a saturating sum and a saturating beat count.
//
// Ports:
//   clk, rst      clock (rising edge) and synchronous active-high reset
//   in_valid      beat present on in_data
//   in_data       N*W bits, channel k at [k*W +: W], unsigned
//   in_last       last beat of an accumulate frame (acc_mode = 1 only)
//   acc_mode      0 = per-beat sum, 1 = frame accumulate
//   out_valid     one-cycle result pulse, L+1 cycles after the beat
//   out_sum       unsigned result, W + log2(N) + ACC_BITS bits
//   out_sat       frame result was clamped
//   out_beats     beats contributing to the result, saturating at 65535
module ai_qcrc_sum_tree #(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int ACC_BITS = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [N*W-1:0]                      in_data,
    input  logic                                in_last,
    input  logic                                acc_mode,
    output logic                                out_valid,
    output logic [W+$clog2(N)+ACC_BITS-1:0]     out_sum,
    output logic                                out_sat,
    output logic [15:0]                         out_beats
);
    localparam int L     = $clog2(N);
    localparam int TW    = W + L;
    localparam int OW    = TW + ACC_BITS;
    localparam int OW1   = OW + 1;
    localparam int NODES = N - 1;

    // Tree nodes are stored flat: stage s occupies indices
    // [N - (N >> s)] .. [N - (N >> (s+1)) - 1]; the last node is the result.
    // Every node is held at the full tree width, which zero-extends each stage.
    logic [TW-1:0] node_q [NODES];
    logic [TW-1:0] node_d [NODES];

    logic [L-1:0]  vld_q, vld_d;
    logic [L-1:0]  last_q, last_d;
    logic [L-1:0]  mode_q, mode_d;

    logic [OW-1:0] acc_q, acc_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          sat_flag_q, sat_flag_d;

    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] out_sum_q, out_sum_d;
    logic          out_sat_q, out_sat_d;
    logic [15:0]   out_beats_q, out_beats_d;

    logic [TW-1:0] tree_sum;
    logic [OW:0]   acc_sum;
    logic          acc_ovf;
    logic [OW-1:0] acc_clamped;
    logic [15:0]   cnt_inc;
    logic          beat_v;
    logic          beat_last;
    logic          beat_mode;

    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            node_d[n] = '0;
        end
        for (int i = 0; i < N / 2; i++) begin
            node_d[i] = TW'(in_data[2*i*W +: W]) + TW'(in_data[(2*i+1)*W +: W]);
        end
        for (int s = 1; s < L; s++) begin
            for (int i = 0; i < (N >> (s + 1)); i++) begin
                node_d[N - (N >> s) + i] = node_q[N - (N >> (s - 1)) + 2*i]
                                         + node_q[N - (N >> (s - 1)) + 2*i + 1];
            end
        end
    end

    // Sideband shift register, one stage per tree stage.
    always_comb begin
        vld_d     = '0;
        last_d    = '0;
        mode_d    = '0;
        vld_d[0]  = in_valid;
        last_d[0] = in_last;
        mode_d[0] = acc_mode;
        for (int s = 1; s < L; s++) begin
            vld_d[s]  = vld_q[s-1];
            last_d[s] = last_q[s-1];
            mode_d[s] = mode_q[s-1];
        end
    end

    assign tree_sum  = node_q[NODES-1];
    assign beat_v    = vld_q[L-1];
    assign beat_last = last_q[L-1];
    assign beat_mode = mode_q[L-1];

    // One extra bit catches the carry out of the accumulator for saturation.
    assign acc_sum     = {1'b0, acc_q} + OW1'(tree_sum);
    assign acc_ovf     = acc_sum[OW];
    assign acc_clamped = acc_ovf ? {OW{1'b1}} : acc_sum[OW-1:0];
    assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_flag_d  = sat_flag_q;
        out_valid_d = 1'b0;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;
        out_beats_d = out_beats_q;
        if (beat_v) begin
            if (!beat_mode) begin
                // Per-beat sum; an open frame is left alone.
                out_valid_d = 1'b1;
                out_sum_d   = OW'(tree_sum);
                out_sat_d   = 1'b0;
                out_beats_d = 16'd1;
            end else if (!beat_last) begin
                acc_d      = acc_clamped;
                cnt_d      = cnt_inc;
                sat_flag_d = sat_flag_q | acc_ovf;
            end else begin
                out_valid_d = 1'b1;
                out_sum_d   = acc_clamped;
                out_sat_d   = sat_flag_q | acc_ovf;
                out_beats_d = cnt_inc;
                acc_d       = '0;
                cnt_d       = '0;
                sat_flag_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            vld_q       <= vld_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_flag_q  <= sat_flag_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
            out_beats_q <= out_beats_d;
        end
    end

    // Datapath and sideband payload need no reset; valid bits gate them.
    always_ff @(posedge clk) begin
        node_q <= node_d;
        last_q <= last_d;
        mode_q <= mode_d;
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;
    assign out_beats = out_beats_q;

endmodule
